// File: rtl/decoder_scan_sequencer.sv
// ---------------------------------------------------------------------------
// decoder_scan_sequencer
//
// Purpose:
//   Drives the address (sel) and enable (en) inputs of a 3-to-8 style decoder
//   so that the decoder outputs are swept one line at a time. Each visited
//   line is held for a programmable dwell time. Only slots enabled in the
//   latched mask are visited. Supports one-shot and continuous sweeps.
//
// Ports:
//   clk    in   1        rising-edge clock
//   rst    in   1        synchronous, active-high reset
//   start  in   1        begin a sweep (only looked at while idle)
//   stop   in   1        abort a sweep / suppress a start in the same cycle
//   mode   in   1        0 = one-shot sweep, 1 = continuous sweeps
//   dwell  in   DWELL_W  cycles per slot, 0 behaves as 1
//   mask   in   N        slot enable, bit i set means slot i is visited
//   sel    out  SEL_W    decoder address
//   en     out  1        decoder enable
//   busy   out  1        high while scanning
//   done   out  1        one-cycle pulse at the end of a one-shot sweep,
//                        or on a start with an empty mask
//   wrap   out  1        one-cycle pulse when a continuous sweep restarts
// ---------------------------------------------------------------------------
module decoder_scan_sequencer #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8,
    localparam int N      = 1 << SEL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [N-1:0]       mask,
    output logic [SEL_W-1:0]   sel,
    output logic               en,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam logic [DWELL_W-1:0] DWELL_ZERO = {DWELL_W{1'b0}};
    localparam logic [DWELL_W-1:0] DWELL_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]       MASK_ZERO  = {N{1'b0}};
    localparam logic [SEL_W-1:0]   SEL_ZERO   = {SEL_W{1'b0}};

    // Index of the lowest set bit of m (0 when m is empty).
    function automatic logic [SEL_W-1:0] lowest_set(input logic [N-1:0] m);
        logic [SEL_W-1:0] idx;
        idx = SEL_ZERO;
        for (int i = N - 1; i >= 0; i--) begin
            idx = m[i] ? SEL_W'(i) : idx;
        end
        return idx;
    endfunction

    // {found, index} of the lowest set bit of m strictly above cur.
    function automatic logic [SEL_W:0] next_set(input logic [N-1:0] m,
                                                input logic [SEL_W-1:0] cur);
        logic             found;
        logic [SEL_W-1:0] idx;
        found = 1'b0;
        idx   = cur;
        for (int i = N - 1; i >= 0; i--) begin
            found = (m[i] && (i > int'(cur))) ? 1'b1 : found;
            idx   = (m[i] && (i > int'(cur))) ? SEL_W'(i) : idx;
        end
        return {found, idx};
    endfunction

    state_t             state_r, state_s;
    logic [SEL_W-1:0]   sel_r, sel_s;
    logic               en_r, en_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               wrap_r, wrap_s;
    logic [DWELL_W-1:0] cnt_r, cnt_s;          // remaining extra cycles in this slot
    logic               mode_lat_r, mode_lat_s;
    logic [N-1:0]       mask_lat_r, mask_lat_s;
    logic [DWELL_W-1:0] dwell_lat_r, dwell_lat_s; // effective dwell, never 0

    logic [DWELL_W-1:0] dwell_eff_s;
    logic               nxt_found_s;
    logic [SEL_W-1:0]   nxt_idx_s;

    assign dwell_eff_s              = (dwell == DWELL_ZERO) ? DWELL_ONE : dwell;
    assign {nxt_found_s, nxt_idx_s} = next_set(mask_lat_r, sel_r);

    // Next-state and next-output logic for the two-state sweep controller.
    always_comb begin
        state_s     = state_r;
        sel_s       = sel_r;
        en_s        = en_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        wrap_s      = 1'b0;
        cnt_s       = cnt_r;
        mode_lat_s  = mode_lat_r;
        mask_lat_s  = mask_lat_r;
        dwell_lat_s = dwell_lat_r;

        case (state_r)
            ST_IDLE: begin
                en_s   = 1'b0;
                busy_s = 1'b0;
                if (start && !stop) begin
                    if (mask != MASK_ZERO) begin
                        mode_lat_s  = mode;
                        mask_lat_s  = mask;
                        dwell_lat_s = dwell_eff_s;
                        sel_s       = lowest_set(mask);
                        en_s        = 1'b1;
                        busy_s      = 1'b1;
                        cnt_s       = dwell_eff_s - DWELL_ONE;
                        state_s     = ST_SCAN;
                    end else begin
                        // Nothing to visit: acknowledge the start immediately.
                        done_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_SCAN: begin
                if (stop) begin
                    // Abort wins over hold, advance and wrap; sel keeps its value.
                    state_s = ST_IDLE;
                    en_s    = 1'b0;
                    busy_s  = 1'b0;
                    cnt_s   = DWELL_ZERO;
                end else if (cnt_r != DWELL_ZERO) begin
                    cnt_s = cnt_r - DWELL_ONE;
                end else if (nxt_found_s) begin
                    sel_s = nxt_idx_s;
                    cnt_s = dwell_lat_r - DWELL_ONE;
                end else if (mode_lat_r) begin
                    sel_s  = lowest_set(mask_lat_r);
                    wrap_s = 1'b1;
                    cnt_s  = dwell_lat_r - DWELL_ONE;
                end else begin
                    state_s = ST_IDLE;
                    en_s    = 1'b0;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    cnt_s   = DWELL_ZERO;
                end
            end

            default: begin
                state_s = ST_IDLE;
                en_s    = 1'b0;
                busy_s  = 1'b0;
                cnt_s   = DWELL_ZERO;
            end
        endcase
    end

    // State, output and latched-configuration registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            sel_r       <= SEL_ZERO;
            en_r        <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            wrap_r      <= 1'b0;
            cnt_r       <= DWELL_ZERO;
            mode_lat_r  <= 1'b0;
            mask_lat_r  <= MASK_ZERO;
            dwell_lat_r <= DWELL_ONE;
        end else begin
            state_r     <= state_s;
            sel_r       <= sel_s;
            en_r        <= en_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            wrap_r      <= wrap_s;
            cnt_r       <= cnt_s;
            mode_lat_r  <= mode_lat_s;
            mask_lat_r  <= mask_lat_s;
            dwell_lat_r <= dwell_lat_s;
        end
    end

    assign sel  = sel_r;
    assign en   = en_r;
    assign busy = busy_r;
    assign done = done_r;
    assign wrap = wrap_r;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for decoder_scan_sequencer.
// A behavioural model describes a sweep as a list of visited slots and an
// elapsed-cycle count since start; expected outputs follow by division and
// modulo. A stand-in 3-to-8 decoder is driven from sel/en.
// ---------------------------------------------------------------------------
module tb_decoder_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] dwell = 8'd0;
    logic [7:0] mask = 8'd0;
    logic [2:0] sel;
    logic       en, busy, done, wrap;
    logic [7:0] dec_y;

    decoder_scan_sequencer #(.SEL_W(3), .DWELL_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .dwell(dwell), .mask(mask), .sel(sel), .en(en), .busy(busy),
        .done(done), .wrap(wrap)
    );

    // decoder_3x8 behaviour: one-hot on Y when enabled, all zero otherwise
    assign dec_y = en ? (8'd1 << sel) : 8'd0;

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // model state
    bit         m_active = 1'b0;
    int         m_t = 0;
    int         m_k = 0;
    int         m_d = 1;
    bit         m_cont = 1'b0;
    logic [7:0] m_mask = 8'd0;
    int         m_slots[8];
    logic [2:0] e_sel = 3'd0;
    bit         e_en = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_wrap = 1'b0;

    // observation of the DUT during directed tests
    int tr_q[$];
    int tr_done = 0;
    int tr_wrap = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        e_done = 1'b0;
        e_wrap = 1'b0;
        if (rst) begin
            m_active = 1'b0;
            e_sel = 3'd0;
        end else if (!m_active) begin
            if (start && !stop) begin
                if (mask == 8'd0) begin
                    e_done = 1'b1;
                end else begin
                    m_k = 0;
                    for (int i = 0; i < 8; i++) begin
                        if (mask[i]) begin
                            m_slots[m_k] = i;
                            m_k++;
                        end
                    end
                    m_d      = (dwell == 8'd0) ? 1 : int'(dwell);
                    m_cont   = mode;
                    m_mask   = mask;
                    m_t      = 0;
                    m_active = 1'b1;
                end
            end
        end else if (stop) begin
            m_active = 1'b0;
        end else begin
            m_t++;
            if (!m_cont && m_t == m_k * m_d) begin
                m_active = 1'b0;
                e_done   = 1'b1;
            end else if (m_cont && (m_t % (m_k * m_d)) == 0) begin
                e_wrap = 1'b1;
            end
        end
        if (m_active) e_sel = 3'(m_slots[(m_t / m_d) % m_k]);
        e_en   = m_active;
        e_busy = m_active;
    endtask

    // One clock: predict, let the edge happen, compare away from the edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("outputs{sel,en,busy,done,wrap}", {sel, en, busy, done, wrap},
              {e_sel, e_en, e_busy, e_done, e_wrap});
        check("decoder_y", dec_y, e_en ? (8'd1 << e_sel) : 8'd0);
        check("en_implies_busy", 32'(en & ~busy), 32'd0);
        check("done_wrap_exclusive", 32'(done & wrap), 32'd0);
        if (en) check("en_slot_in_mask", 32'(m_mask[sel]), 32'd1);
        if (en) tr_q.push_back(int'(sel));
        if (done) tr_done++;
        if (wrap) tr_wrap++;
    endtask

    task automatic clear_trace();
        tr_q.delete();
        tr_done = 0;
        tr_wrap = 0;
    endtask

    initial begin
        int sparse_exp[3];
        int ign_exp[4];
        int found;
        sparse_exp[0] = 2; sparse_exp[1] = 5; sparse_exp[2] = 7;
        ign_exp[0] = 2; ign_exp[1] = 2; ign_exp[2] = 3; ign_exp[3] = 3;

        // reset then idle
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        repeat (20) cycle();
        check("idle_pin", {sel, en, busy, done, wrap}, 32'd0);

        // one-shot full sweep, dwell 2
        clear_trace();
        mask = 8'hFF; dwell = 8'd2; mode = 1'b0; start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (20) cycle();
        check("full_en_cycles", tr_q.size(), 32'd16);
        for (int i = 0; i < 16 && i < tr_q.size(); i++) check("full_sel_seq", tr_q[i], i / 2);
        check("full_done_count", tr_done, 32'd1);
        check("full_busy_after", 32'(busy), 32'd0);

        // sparse mask, dwell 0 behaves as 1
        clear_trace();
        mask = 8'b1010_0100; dwell = 8'd0; start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (6) cycle();
        check("sparse_len", tr_q.size(), 32'd3);
        for (int i = 0; i < 3 && i < tr_q.size(); i++) check("sparse_sel_seq", tr_q[i], sparse_exp[i]);
        check("sparse_done_count", tr_done, 32'd1);

        // continuous sweeps with wrap, then stop
        clear_trace();
        mask = 8'h81; dwell = 8'd3; mode = 1'b1; start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (17) cycle();
        check("cont_len", tr_q.size(), 32'd18);
        for (int i = 0; i < 18 && i < tr_q.size(); i++)
            check("cont_sel_seq", tr_q[i], ((i / 3) % 2 == 1) ? 7 : 0);
        check("cont_wrap_count", tr_wrap, 32'd2);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        check("stop_en_low", {en, busy, done}, 32'd0);
        repeat (3) cycle();
        check("stop_no_done", tr_done, 32'd0);

        // start with empty mask
        clear_trace();
        mask = 8'h00; mode = 1'b0; start = 1'b1;
        cycle();
        start = 1'b0;
        check("empty_done_pulse", {en, busy, done}, 32'd1);
        repeat (3) cycle();
        check("empty_no_en", tr_q.size(), 32'd0);

        // start and stop together
        clear_trace();
        mask = 8'hFF; start = 1'b1; stop = 1'b1;
        cycle();
        start = 1'b0; stop = 1'b0;
        repeat (5) cycle();
        check("startstop_no_en", tr_q.size(), 32'd0);
        check("startstop_no_done", tr_done, 32'd0);

        // start held during SCAN and inputs changed mid-sweep are ignored
        clear_trace();
        mask = 8'h0C; dwell = 8'd2; start = 1'b1;
        cycle();
        mask = 8'hF0; dwell = 8'd5; mode = 1'b1;
        cycle();
        cycle();
        start = 1'b0; mode = 1'b0;
        repeat (5) cycle();
        check("ignore_len", tr_q.size(), 32'd4);
        for (int i = 0; i < 4 && i < tr_q.size(); i++) check("ignore_sel_seq", tr_q[i], ign_exp[i]);
        check("ignore_done_count", tr_done, 32'd1);

        // maximum dwell on a single slot
        clear_trace();
        mask = 8'h01; dwell = 8'd255; mode = 1'b0; start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (260) cycle();
        check("maxdwell_len", tr_q.size(), 32'd255);
        check("maxdwell_done", tr_done, 32'd1);

        // reset mid-sweep, then re-run with the decoder observed
        mask = 8'hFF; dwell = 8'd4; start = 1'b1;
        cycle();
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            if (en && sel == 3'd3) found = 1;
            else cycle();
        end
        check("reach_sel3", {en, sel}, {1'b1, 3'd3});
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("midreset_outputs", {sel, en, busy, done, wrap}, 32'd0);
        check("midreset_dec_y", dec_y, 32'd0);
        clear_trace();
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (40) cycle();
        check("rerun_len", tr_q.size(), 32'd32);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            rst   = ($urandom_range(199, 0) == 0);
            start = ($urandom_range(7, 0) == 0);
            stop  = ($urandom_range(39, 0) == 0);
            mode  = 1'($urandom_range(1, 0));
            case ($urandom_range(9, 0))
                0:       mask = 8'h00;
                1, 2:    mask = 8'd1 << $urandom_range(7, 0);
                default: mask = 8'($urandom);
            endcase
            if ($urandom_range(49, 0) == 0) dwell = 8'($urandom);
            else dwell = 8'($urandom_range(3, 0));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
